alu_core: RTL and testbench

- Registered 32-bit integer ALU for the pipelined RISC-V datapath, sitting in the EX stage.
- Computes AND/OR/XOR/ADD/SUB/shift/set-less-than on SrcA/SrcB selected by a 4-bit Operation code.
- Registers the result and a Zero flag with one cycle of latency.
- Uses a simple valid qualifier so downstream stages know when the output is fresh.

---
 rtl/alu_core.sv | 120 ++++++++++++
 tb/tb_alu_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered 32-bit integer ALU for the EX stage: one-cycle latency, valid-qualified output.
// Define ALU_FLAGS_EN to add registered Carry/Overflow/Negative outputs.
module alu_core #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
`endif
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSll  = 4'b0111;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSlt  = 4'b1001;
    localparam logic [3:0] OpSltu = 4'b1010;
    localparam logic [3:0] OpSra  = 4'b1011;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;
    logic               slt_bit;
    logic               sltu_bit;

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign slt_bit  = $signed(SrcA) < $signed(SrcB);
    assign sltu_bit = SrcA < SrcB;

    // Undefined opcodes yield 0 so downstream sees Zero=1.
    always_comb begin
        result = '0;
        case (Operation)
            OpAnd:   result = SrcA & SrcB;
            OpOr:    result = SrcA | SrcB;
            OpAdd:   result = SrcA + SrcB;
            OpXor:   result = SrcA ^ SrcB;
            OpSub:   result = SrcA - SrcB;
            OpSll:   result = SrcA << shamt;
            OpSrl:   result = SrcA >> shamt;
            OpSlt:   result = {{(WIDTH-1){1'b0}}, slt_bit};
            OpSltu:  result = {{(WIDTH-1){1'b0}}, sltu_bit};
            OpSra:   result = $unsigned($signed(SrcA) >>> shamt);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResult <= '0;
            Zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ALUResult <= result;
                Zero      <= (result == '0);
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;
    logic           carry_d;
    logic           overflow_d;

    assign add_ext = {1'b0, SrcA} + {1'b0, SrcB};
    assign sub_ext = {1'b0, SrcA} - {1'b0, SrcB};

    // For SUB, carry is the inverted borrow (1 when A >= B unsigned).
    always_comb begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (Operation)
            OpAdd: begin
                carry_d    = add_ext[WIDTH];
                overflow_d = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                             (add_ext[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OpSub: begin
                carry_d    = ~sub_ext[WIDTH];
                overflow_d = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                             (sub_ext[WIDTH-1] != SrcA[WIDTH-1]);
            end
            default: begin
                carry_d    = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Negative <= 1'b0;
        end else if (in_valid) begin
            Carry    <= carry_d;
            Overflow <= overflow_d;
            Negative <= result[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic        Carry;
    logic        Overflow;
    logic        Negative;
`endif

    int checks = 0;
    int errors = 0;

    alu_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Negative  (Negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model from the operation table, using plain integer arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned s;
        logic [31:0] r;
        s = b % 32;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a ^ b;
            4'd6:    r = a - b;
            4'd7:    r = a << s;
            4'd8:    r = a >> s;
            4'd9:    r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd10:   r = (a < b) ? 32'd1 : 32'd0;
            4'd11:   r = a[31] ? ~((~a) >> s) : (a >> s);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_valid;
`ifdef ALU_FLAGS_EN
    logic        exp_carry, exp_ovf, exp_neg;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_res   = 32'd0;
            exp_zero  = 1'b0;
            exp_valid = 1'b0;
`ifdef ALU_FLAGS_EN
            exp_carry = 1'b0;
            exp_ovf   = 1'b0;
            exp_neg   = 1'b0;
`endif
        end else begin
            exp_valid = in_valid;
            if (in_valid) begin
                exp_res  = model(Operation, SrcA, SrcB);
                exp_zero = (exp_res == 32'd0);
`ifdef ALU_FLAGS_EN
                begin
                    logic [63:0] wide;
                    longint      ssum;
                    exp_carry = 1'b0;
                    exp_ovf   = 1'b0;
                    if (Operation == 4'd2) begin
                        wide      = 64'(SrcA) + 64'(SrcB);
                        exp_carry = wide[32];
                        ssum      = longint'(int'(SrcA)) + longint'(int'(SrcB));
                        exp_ovf   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
                    end else if (Operation == 4'd6) begin
                        exp_carry = (SrcA >= SrcB);
                        ssum      = longint'(int'(SrcA)) - longint'(int'(SrcB));
                        exp_ovf   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
                    end
                    exp_neg = exp_res[31];
                end
`endif
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("model_result", ALUResult, exp_res);
            chk("model_zero", 32'(Zero), 32'(exp_zero));
            chk("model_valid", 32'(out_valid), 32'(exp_valid));
`ifdef ALU_FLAGS_EN
            chk("model_carry", 32'(Carry), 32'(exp_carry));
            chk("model_overflow", 32'(Overflow), 32'(exp_ovf));
            chk("model_negative", 32'(Negative), 32'(exp_neg));
`endif
        end
    end

    // One valid operation; checks DUT against a hand-computed literal one cycle later.
    task automatic op_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk);
        #1;
        chk({name, "_result"}, ALUResult, expected);
        chk({name, "_zero"}, 32'(Zero), (expected == 32'd0) ? 32'd1 : 32'd0);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        Operation = 4'd0;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        #2;
        chk("reset_result", ALUResult, 32'd0);
        chk("reset_zero", 32'(Zero), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        op_lit("and",  4'b0000, 32'h113C2DE4, 32'hFB0B4877, 32'h11080864);
        op_lit("or",   4'b0001, 32'h113C2DE4, 32'hFB0B4877, 32'hFB3F6DF7);
        op_lit("xor",  4'b0011, 32'h113C2DE4, 32'hFB0B4877, 32'hEA376593);
        op_lit("add",  4'b0010, 32'h113C2DE4, 32'hFB0B4877, 32'h0C47765B);
        op_lit("sub",  4'b0110, 32'h113C2DE4, 32'hFB0B4877, 32'h1630E56D);
        op_lit("sll",  4'b0111, 32'h113C2DE4, 32'h0000000A, 32'hF0B79000);
        op_lit("srl",  4'b1000, 32'h113C2DE4, 32'h0000000A, 32'h00044F0B);
        op_lit("sra",  4'b1011, 32'hFB0B4877, 32'h0000000A, 32'hFFFEC2D2);
        op_lit("slt0", 4'b1001, 32'h113C2DE4, 32'h0000000A, 32'h00000000);
        op_lit("sltu0", 4'b1010, 32'h113C2DE4, 32'h0000000A, 32'h00000000);
        op_lit("slt1", 4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        op_lit("sltu1", 4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        op_lit("slt2", 4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000);
        op_lit("sltu2", 4'b1010, 32'h00000001, 32'hFFFFFFFF, 32'h00000001);
        op_lit("subeq", 4'b0110, 32'h12345678, 32'h12345678, 32'h00000000);
        op_lit("illegal", 4'b0100, 32'h113C2DE4, 32'hFB0B4877, 32'h00000000);
        op_lit("sll_sh0", 4'b0111, 32'h113C2DE4, 32'hFFFFFFE0, 32'h113C2DE4);
        op_lit("sra_sh0", 4'b1011, 32'hFB0B4877, 32'hFFFFFFE0, 32'hFB0B4877);
        op_lit("sll_sh31", 4'b0111, 32'h00000003, 32'h0000001F, 32'h80000000);
        op_lit("sra_sh31", 4'b1011, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF);
        op_lit("add_wrap", 4'b0010, 32'h80000000, 32'h80000000, 32'h00000000);
        op_lit("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);

        // Idle cycles: operands change but the captured result must hold.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            Operation = 4'b0010;
            SrcA      = 32'h1000 + 32'(i);
            SrcB      = 32'h5;
            @(posedge clk);
            #1;
            chk("idle_result", ALUResult, 32'h80000000);
            chk("idle_valid", 32'(out_valid), 32'd0);
            chk("idle_zero", 32'(Zero), 32'd0);
        end

        // Reset mid-operation: clears immediately and the pending result is dropped.
        op_lit("pre_rst", 4'b0001, 32'h0000F000, 32'h0000000F, 32'h0000F00F);
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 4'b0011;
        SrcA      = 32'hAAAA5555;
        SrcB      = 32'h0F0F0F0F;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_result", ALUResult, 32'd0);
        chk("async_rst_zero", 32'(Zero), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_result", ALUResult, 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        op_lit("after_rst", 4'b0011, 32'hAAAA5555, 32'h0F0F0F0F, 32'hA5A55A5A);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
